fm_write_queue: RTL
===================

# fm_write_queue

Buffered write scheduler in front of the FM synthesizer register bus. Host register writes are queued in a FIFO and replayed in order onto the synth bus. While the synth is busy computing a sample, it stalls writes with a wait signal; this block absorbs those stalls so the host never does. A reserved delay address lets the host schedule register changes a given number of sample ticks apart.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries of {addr[7:0], data[31:0]}.
- DELAY_ADDR, 8'h02: queued entries with this address are delay commands and are never issued to the synth.

- clk  in  1  system clock; the single clock for the block.
- reset  in  1  asynchronous, active-high reset.
- in_addr  in  8  host write address.
- in_wrdata  in  32  host write data.
- in_wren  in  1  host push request; accepted on any edge where in_full=0 and flush=0.
- in_full  out  1  FIFO full; combinational from the registered level.
- level  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- overflow  out  1  sticky flag; set on in_wren while in_full=1; cleared by flush.
- flush  in  1  single-cycle request: empty the FIFO and abort any pending issue or delay.
- tick  in  1  one-cycle sample strobe; advances delay commands.
- fm_addr  out  8  synth bus address.
- fm_wrdata  out  32  synth bus write data.
- fm_wren  out  1  synth bus write enable.
- fm_wait  in  1  synth stall; a write completes on the edge where fm_wren=1 and fm_wait=0.
- busy  out  1  high when the FIFO is non-empty or the state is not IDLE.

## Operation
- Reset values: level=0, in_full=0, overflow=0, fm_addr=0, fm_wrdata=0, fm_wren=0, busy=0, state=IDLE, delay counter=0.
- FIFO:
  - Circular buffer with rd/wr pointers of DEPTH_LOG2 bits that wrap modulo depth.
  - Push and pop can occur in the same cycle; level is then unchanged.
  - A push while in_full=1 is dropped, even if a pop happens in that cycle, and sets overflow.
- Drain state machine, states IDLE, ISSUE, DELAY:
  - IDLE, FIFO empty: stay in IDLE.
  - IDLE, FIFO non-empty, head addr==DELAY_ADDR:
    - Load the counter with head data[15:0] and pop.
    - Go to DELAY; fm_wren stays 0.
  - IDLE, FIFO non-empty, other head:
    - Register head addr/data onto fm_addr/fm_wrdata and set fm_wren=1.
    - Go to ISSUE. No pop yet.
  - ISSUE, fm_wait=1: hold fm_addr, fm_wrdata and fm_wren=1 unchanged.
  - ISSUE, fm_wait=0: the write is accepted on this edge. Pop, clear fm_wren, go to IDLE.
  - DELAY, counter==0: go to IDLE.
  - DELAY, otherwise: decrement the counter on each edge with tick=1.
- Delay arithmetic:
  - The counter is 16 bits.
  - Delay N ends after N tick pulses.
  - N=0 spends exactly one cycle in DELAY.
- flush:
  - On the edge with flush=1, set level=0 with rd=wr pointers, clear overflow, clear fm_wren and go to IDLE.
  - A write whose acceptance coincides with flush (ISSUE, fm_wait=0) counts as delivered.
  - A simultaneous in_wren is discarded without setting overflow.
- fm_addr/fm_wrdata keep their last value when fm_wren=0.

## Timing
- Push latency: an entry pushed at edge T is visible to IDLE at cycle T+1. fm_wren rises at edge T+1.
- With fm_wait=0 throughout, each write occupies 2 cycles (IDLE, ISSUE), so fm_wren toggles 1,0,1,0…
- Stall: fm_wren is held for 1 + (number of fm_wait=1 cycles in ISSUE) cycles.
- in_full and level update on the edge after a push or pop.
- A delay entry costs 1 IDLE cycle plus DELAY cycles. The following write's fm_wren rises 2 edges after the tick that reaches 0.
- Reset mid-operation returns all state and outputs to their reset values immediately; queued entries are lost.

## Test plan
- Basic order:
  - Stimulus: push (00,0000FFFF), (60,00012000), (61,00003000); fm_wait=0.
  - Response: exactly three fm_wren pulses, 2 cycles apart, with matching addr/data in order; level returns to 0; busy falls.
- Stall:
  - Stimulus: hold fm_wait=1 for 7 cycles while one write is in ISSUE.
  - Response: fm_wren is high for 8 cycles with stable addr/data; exactly one pop.
- Full/overflow (DEPTH_LOG2=4):
  - Stimulus: fm_wait=1, push 17 entries.
  - Response: level=16 and in_full=1; the 17th entry is dropped; overflow=1.
  - Then release fm_wait: 16 writes emerge, the 17th never appears.
- Delay:
  - Stimulus: queue write A, (02,00000003), write B; tick every 100 cycles.
  - Response: B is issued 2 edges after the 3rd tick following A; delay entries are never seen on fm_wren. (02,00000000) adds 1 cycle only.
- Flush:
  - Stimulus: flush during DELAY with 5 entries queued.
  - Response: next cycle level=0, state IDLE, overflow=0; no further fm_wren. A push simultaneous with flush is discarded.
- Async reset:
  - Stimulus: assert reset while in ISSUE with fm_wait=1.
  - Response: fm_wren=0, level=0 and busy=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/fm_write_queue.sv
// fm_write_queue: FIFO-buffered replay of host register writes onto the
// FM synth bus, absorbing fm_wait stalls and honouring queued tick delays.
module fm_write_queue #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  DELAY_ADDR = 8'h02
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_addr,
  input  logic [31:0]         in_wrdata,
  input  logic                in_wren,
  output logic                in_full,
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                flush,
  input  logic                tick,
  output logic [7:0]          fm_addr,
  output logic [31:0]         fm_wrdata,
  output logic                fm_wren,
  input  logic                fm_wait,
  output logic                busy
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DELAY
  } state_e;

  state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  wren_q, wren_d;

  logic [39:0] mem_q [DEPTH];

  logic        empty;
  logic        push;
  logic        pop;
  logic [7:0]  head_addr;
  logic [31:0] head_data;

  assign empty     = (level_q == '0);
  assign in_full   = (level_q == LVL_FULL);
  assign push      = in_wren & ~in_full & ~flush;
  assign head_addr = mem_q[rd_ptr_q][39:32];
  assign head_data = mem_q[rd_ptr_q][31:0];

  assign level     = level_q;
  assign overflow  = ovf_q;
  assign fm_addr   = addr_q;
  assign fm_wrdata = data_q;
  assign fm_wren   = wren_q;
  assign busy      = ~empty | (state_q != S_IDLE);

  // Drain FSM: delay entries are consumed at once, writes pop on acceptance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = wren_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_addr == DELAY_ADDR) begin
            cnt_d   = head_data[15:0];
            pop     = 1'b1;
            state_d = S_DELAY;
          end else begin
            addr_d  = head_addr;
            data_d  = head_data;
            wren_d  = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!fm_wait) begin
          pop     = 1'b1;
          wren_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Flush keeps the bus fields frozen so fm_addr/fm_wrdata do not move
    if (flush) begin
      state_d = S_IDLE;
      wren_d  = 1'b0;
      cnt_d   = '0;
      addr_d  = addr_q;
      data_d  = data_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (in_wren & in_full & ~flush);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_addr, in_wrdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
    end
  end

endmodule
